// File: rtl/phys_reg_free_list.sv
// Circular free list of physical register tags: show-ahead head for rename,
// releases from commit, per-tag membership tracking with sticky error flags.
module phys_reg_free_list #(
  parameter int NUM_PHYSICAL_REGS = 64,
  parameter int NUM_ARCH_REGS     = 32,
  parameter int TAG_WIDTH         = 6,
  localparam int DEPTH            = NUM_PHYSICAL_REGS - NUM_ARCH_REGS,
  localparam int CNT_W            = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 free_list_read,
  output logic [TAG_WIDTH-1:0] free_list_tag,
  output logic                 free_list_valid,
  input  logic                 free_valid,
  input  logic [TAG_WIDTH-1:0] free_tag,
  output logic [CNT_W-1:0]     free_count,
  output logic                 err_overflow,
  output logic                 err_double_free
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [TAG_WIDTH:0] NUM_PHYS_L  = (TAG_WIDTH+1)'(NUM_PHYSICAL_REGS);
  localparam logic [PTR_W-1:0]   PTR_LAST_L  = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]   CNT_FULL_L  = CNT_W'(DEPTH);

  logic [TAG_WIDTH-1:0]       mem_r [DEPTH];
  logic [PTR_W-1:0]           head_r;
  logic [PTR_W-1:0]           tail_r;
  logic [CNT_W-1:0]           count_r;
  logic [NUM_PHYSICAL_REGS-1:0] in_list_r;
  logic                       err_overflow_r;
  logic                       err_double_free_r;

  logic pop_fire_s;
  logic range_ok_s;
  logic dup_s;
  logic room_s;
  logic push_ok_s;
  logic set_dfree_s;
  logic set_ovf_s;
  logic [CNT_W-1:0] count_next_s;

  // Pointers wrap explicitly since DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_LAST_L) begin
      return '0;
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  // Pop/push qualification and drop classification from pre-edge state.
  always_comb begin
    pop_fire_s = free_list_read && (count_r != '0);
    range_ok_s = ({1'b0, free_tag} < NUM_PHYS_L);
    if (range_ok_s) begin
      dup_s = in_list_r[free_tag];
    end else begin
      dup_s = 1'b0;
    end
    room_s      = (count_r != CNT_FULL_L) || pop_fire_s;
    push_ok_s   = free_valid && range_ok_s && !dup_s && room_s;
    set_dfree_s = free_valid && (!range_ok_s || dup_s);
    set_ovf_s   = free_valid && range_ok_s && !dup_s && !room_s;
    case ({push_ok_s, pop_fire_s})
      2'b10:   count_next_s = count_r + CNT_W'(1);
      2'b01:   count_next_s = count_r - CNT_W'(1);
      default: count_next_s = count_r;
    endcase
  end

  // List state, membership vector and sticky error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= TAG_WIDTH'(NUM_ARCH_REGS + i);
      end
      for (int t = 0; t < NUM_PHYSICAL_REGS; t++) begin
        in_list_r[t] <= (t >= NUM_ARCH_REGS) ? 1'b1 : 1'b0;
      end
      head_r            <= '0;
      tail_r            <= '0;
      count_r           <= CNT_FULL_L;
      err_overflow_r    <= 1'b0;
      err_double_free_r <= 1'b0;
    end else begin
      // A same-cycle pop and push never touch the same tag: that release is a duplicate.
      if (pop_fire_s) begin
        head_r                   <= ptr_inc(head_r);
        in_list_r[mem_r[head_r]] <= 1'b0;
      end
      if (push_ok_s) begin
        mem_r[tail_r]       <= free_tag;
        tail_r              <= ptr_inc(tail_r);
        in_list_r[free_tag] <= 1'b1;
      end
      count_r <= count_next_s;
      if (set_ovf_s) begin
        err_overflow_r <= 1'b1;
      end
      if (set_dfree_s) begin
        err_double_free_r <= 1'b1;
      end
    end
  end

  assign free_list_tag   = mem_r[head_r];
  assign free_list_valid = (count_r != '0);
  assign free_count      = count_r;
  assign err_overflow    = err_overflow_r;
  assign err_double_free = err_double_free_r;

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Randomized and directed bench for phys_reg_free_list against a queue-based
// reference model of the free list.
module tb_phys_reg_free_list;

  logic       clk;
  logic       rst;
  logic       free_list_read;
  logic [5:0] free_list_tag;
  logic       free_list_valid;
  logic       free_valid;
  logic [5:0] free_tag;
  logic [5:0] free_count;
  logic       err_overflow;
  logic       err_double_free;

  int errors;
  int checks;

  // Reference model: FIFO of free tags, membership set, sticky flags.
  int q[$];
  bit inl[64];
  bit m_ovf;
  bit m_dfree;

  phys_reg_free_list dut (
    .clk             (clk),
    .rst             (rst),
    .free_list_read  (free_list_read),
    .free_list_tag   (free_list_tag),
    .free_list_valid (free_list_valid),
    .free_valid      (free_valid),
    .free_tag        (free_tag),
    .free_count      (free_count),
    .err_overflow    (err_overflow),
    .err_double_free (err_double_free)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    for (int t = 0; t < 64; t++) inl[t] = (t >= 32);
    for (int t = 32; t < 64; t++) q.push_back(t);
    m_ovf = 1'b0;
    m_dfree = 1'b0;
  endtask

  task automatic model_update(input bit r, input bit rd, input bit fv, input int ft);
    bit pop;
    bit dup;
    bit room;
    int t;
    if (r) begin
      model_reset();
    end else begin
      pop  = rd && (q.size() != 0);
      dup  = inl[ft];
      room = (q.size() < 32) || pop;
      if (pop) begin
        t = q.pop_front();
        inl[t] = 1'b0;
      end
      if (fv) begin
        if (dup) m_dfree = 1'b1;
        else if (!room) m_ovf = 1'b1;
        else begin
          q.push_back(ft);
          inl[ft] = 1'b1;
        end
      end
    end
  endtask

  task automatic compare_all();
    check("valid", int'(free_list_valid), int'(q.size() != 0));
    check("count", int'(free_count), q.size());
    if (q.size() != 0) check("head_tag", int'(free_list_tag), q[0]);
    check("err_overflow", int'(err_overflow), int'(m_ovf));
    check("err_double_free", int'(err_double_free), int'(m_dfree));
  endtask

  task automatic step(input bit r, input bit rd, input bit fv, input int ft);
    @(negedge clk);
    rst = r;
    free_list_read = rd;
    free_valid = fv;
    free_tag = 6'(ft);
    @(posedge clk);
    model_update(r, rd, fv, ft);
    #1;
    compare_all();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    free_list_read = 1'b0;
    free_valid = 1'b0;
    free_tag = 6'd0;
    model_reset();

    // Reset state
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    check("rst_valid", int'(free_list_valid), 1);
    check("rst_tag", int'(free_list_tag), 32);
    check("rst_count", int'(free_count), 32);
    check("rst_errs", int'({err_overflow, err_double_free}), 0);

    // Drain in order 32..63
    for (int i = 0; i < 32; i++) step(0, 1, 0, 0);
    check("drained_valid", int'(free_list_valid), 0);
    check("drained_count", int'(free_count), 0);
    step(0, 1, 0, 0);  // read while empty is ignored

    // Release while empty with read: no bypass
    step(0, 1, 1, 5);
    check("empty_rel_tag", int'(free_list_tag), 5);
    check("empty_rel_count", int'(free_count), 1);
    step(0, 1, 0, 0);

    // Fill across pointer wrap, then drain
    for (int i = 0; i < 32; i++) step(0, 0, 1, (i * 7 + 3) % 32);
    check("wrap_full_count", int'(free_count), 32);
    for (int i = 0; i < 32; i++) step(0, 1, 0, 0);
    check("wrap_empty_count", int'(free_count), 0);

    // Overflow, then pop+release on a full list
    step(1, 0, 0, 0);
    step(0, 0, 1, 10);
    check("ovf_flag", int'(err_overflow), 1);
    check("ovf_count", int'(free_count), 32);
    step(0, 1, 1, 11);
    check("fullpp_count", int'(free_count), 32);
    for (int i = 0; i < 31; i++) step(0, 1, 0, 0);
    check("fullpp_tag11", int'(free_list_tag), 11);

    // Double frees
    step(1, 0, 0, 0);
    step(0, 0, 1, 40);
    check("dfree_40", int'(err_double_free), 1);
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 1, 33);
    check("dfree_33", int'(err_double_free), 1);
    check("dfree_33_count", int'(free_count), 30);
    check("dfree_33_tag", int'(free_list_tag), 34);

    // Mid-stream reset discards in-flight release
    for (int i = 0; i < 8; i++) step(0, 1, 0, 0);
    step(0, 0, 1, 33);
    step(1, 1, 1, 5);
    check("mid_rst_tag", int'(free_list_tag), 32);
    check("mid_rst_count", int'(free_count), 32);
    check("mid_rst_errs", int'({err_overflow, err_double_free}), 0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 99) < 55), int'($urandom_range(0, 63)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
